// File: rtl/fatori_mon_err_ctrl.sv
// fatori_mon_err_ctrl: error counters, sticky source mask and bounded retry/fatal sequencing for M-of-N hardened wrappers
module fatori_mon_err_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W = 16,
  parameter int MAX_RETRY = 2,
  parameter int MIN_THR = 8,
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] min_err_i,
  input  logic [NUM_SRC-1:0] maj_err_i,
  input  logic [NUM_SRC-1:0] scrub_i,
  input  logic               ex_valid_i,
  input  logic               ex_done_i,
  input  logic               retry_ack_i,
  input  logic               clear_i,
  output logic               retry_req_o,
  output logic               stall_o,
  output logic               fatal_o,
  output logic               minor_alert_o,
  output logic [CNT_W-1:0]   min_cnt_o,
  output logic [CNT_W-1:0]   maj_cnt_o,
  output logic [CNT_W-1:0]   scrub_cnt_o,
  output logic [NUM_SRC-1:0] err_src_o,
  output logic [RW-1:0]      retry_cnt_o
);
  typedef enum logic [1:0] {IDLE, RETRY_REQ, REEXEC, FATAL} state_e;
  state_e state_q, state_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [CNT_W-1:0] min_cnt_q, min_cnt_d, maj_cnt_q, maj_cnt_d, scr_cnt_q, scr_cnt_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic alert_q, alert_d;
  logic maj_any, min_any, scr_any, maj_hit;
  assign maj_any = |maj_err_i;
  assign min_any = |min_err_i;
  assign scr_any = |scrub_i;
  assign maj_hit = maj_any && ex_valid_i;
  always_comb begin
    state_d = state_q;
    rc_d = rc_q;
    case (state_q)
      IDLE:
        if (maj_hit) begin
          state_d = MAX_RETRY == 0 ? FATAL : RETRY_REQ;
          rc_d = MAX_RETRY == 0 ? rc_q : RW'(1);
        end
      RETRY_REQ: state_d = retry_ack_i ? REEXEC : RETRY_REQ;
      REEXEC:
        if (maj_hit) begin
          state_d = rc_q == RW'(MAX_RETRY) ? FATAL : RETRY_REQ;
          rc_d = rc_q == RW'(MAX_RETRY) ? rc_q : rc_q + RW'(1);
        end else if (ex_done_i) begin
          state_d = IDLE;
          rc_d = '0;
        end
      default: state_d = FATAL;
    endcase
  end
  always_comb begin
    min_cnt_d = clear_i ? '0 : (min_any && min_cnt_q != '1) ? min_cnt_q + CNT_W'(1) : min_cnt_q;
    maj_cnt_d = clear_i ? '0 : (maj_any && maj_cnt_q != '1) ? maj_cnt_q + CNT_W'(1) : maj_cnt_q;
    scr_cnt_d = clear_i ? '0 : (scr_any && scr_cnt_q != '1) ? scr_cnt_q + CNT_W'(1) : scr_cnt_q;
    src_d = clear_i ? '0 : src_q | min_err_i | maj_err_i;
    alert_d = !clear_i && min_any && min_cnt_q == CNT_W'(MIN_THR - 1);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rc_q <= '0;
      min_cnt_q <= '0;
      maj_cnt_q <= '0;
      scr_cnt_q <= '0;
      src_q <= '0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q <= rc_d;
      min_cnt_q <= min_cnt_d;
      maj_cnt_q <= maj_cnt_d;
      scr_cnt_q <= scr_cnt_d;
      src_q <= src_d;
      alert_q <= alert_d;
    end
  end
  assign retry_req_o = state_q == RETRY_REQ;
  assign stall_o = state_q == RETRY_REQ || state_q == FATAL;
  assign fatal_o = state_q == FATAL;
  assign minor_alert_o = alert_q;
  assign min_cnt_o = min_cnt_q;
  assign maj_cnt_o = maj_cnt_q;
  assign scrub_cnt_o = scr_cnt_q;
  assign err_src_o = src_q;
  assign retry_cnt_o = rc_q;
endmodule

// File: tb/tb_fatori_mon_err_ctrl.sv
// tb_fatori_mon_err_ctrl: randomized and directed checks of fatori_mon_err_ctrl against a behavioural model
module tb_fatori_mon_err_ctrl;
  localparam int MAX_RETRY = 2;
  localparam int MIN_THR = 8;
  localparam int SAT = 15;
  localparam int M_IDLE = 0, M_REQ = 1, M_REEXEC = 2, M_FATAL = 3;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [3:0] min_err_i = '0, maj_err_i = '0, scrub_i = '0;
  logic ex_valid_i = 1'b0, ex_done_i = 1'b0, retry_ack_i = 1'b0, clear_i = 1'b0;
  logic retry_req_o, stall_o, fatal_o, minor_alert_o;
  logic [3:0] min_cnt_o, maj_cnt_o, scrub_cnt_o, err_src_o;
  logic [1:0] retry_cnt_o;
  int n_cmp = 0;
  int n_fail = 0;
  int m_mode, m_rc, m_min, m_maj, m_scr;
  logic [3:0] m_src;
  logic m_alert;
  always #5 clk = ~clk;
  fatori_mon_err_ctrl #(.NUM_SRC(4), .CNT_W(4), .MAX_RETRY(MAX_RETRY), .MIN_THR(MIN_THR)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .min_err_i(min_err_i), .maj_err_i(maj_err_i), .scrub_i(scrub_i),
    .ex_valid_i(ex_valid_i), .ex_done_i(ex_done_i), .retry_ack_i(retry_ack_i), .clear_i(clear_i),
    .retry_req_o(retry_req_o), .stall_o(stall_o), .fatal_o(fatal_o), .minor_alert_o(minor_alert_o),
    .min_cnt_o(min_cnt_o), .maj_cnt_o(maj_cnt_o), .scrub_cnt_o(scrub_cnt_o), .err_src_o(err_src_o),
    .retry_cnt_o(retry_cnt_o)
  );
  task automatic step(input logic r, input logic [3:0] mn, input logic [3:0] mj, input logic [3:0] sc,
                      input logic v, input logic d, input logic a, input logic c);
    int old;
    rst_ni = r; min_err_i = mn; maj_err_i = mj; scrub_i = sc;
    ex_valid_i = v; ex_done_i = d; retry_ack_i = a; clear_i = c;
    @(posedge clk);
    if (!r) begin
      m_mode = M_IDLE; m_rc = 0; m_min = 0; m_maj = 0; m_scr = 0; m_src = '0; m_alert = 1'b0;
    end else begin
      if (m_mode == M_IDLE && |mj && v) begin
        m_mode = MAX_RETRY == 0 ? M_FATAL : M_REQ;
        if (MAX_RETRY != 0) m_rc = 1;
      end else if (m_mode == M_REQ && a) m_mode = M_REEXEC;
      else if (m_mode == M_REEXEC && |mj && v) begin
        if (m_rc >= MAX_RETRY) m_mode = M_FATAL;
        else begin m_rc++; m_mode = M_REQ; end
      end else if (m_mode == M_REEXEC && d) begin
        m_mode = M_IDLE; m_rc = 0;
      end
      old = m_min;
      if (c) begin
        m_min = 0; m_maj = 0; m_scr = 0; m_src = '0;
      end else begin
        if (|mn) m_min = m_min + 1 > SAT ? SAT : m_min + 1;
        if (|mj) m_maj = m_maj + 1 > SAT ? SAT : m_maj + 1;
        if (|sc) m_scr = m_scr + 1 > SAT ? SAT : m_scr + 1;
        m_src = m_src | mn | mj;
      end
      m_alert = !c && old < MIN_THR && m_min >= MIN_THR;
    end
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) step(0, '1, '1, '1, 1, 1, 1, 1);
    n_cmp++;
    if ({retry_req_o, stall_o, fatal_o, minor_alert_o, min_cnt_o, maj_cnt_o, scrub_cnt_o, err_src_o, retry_cnt_o} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b stall=%b fatal=%b alert=%b min=%0d maj=%0d scr=%0d src=%b rc=%0d, want all 0",
               retry_req_o, stall_o, fatal_o, minor_alert_o, min_cnt_o, maj_cnt_o, scrub_cnt_o, err_src_o, retry_cnt_o);
    end
    step(1, '0, 4'b1000, '0, 1, 0, 0, 0);
    n_cmp++;
    if ({retry_req_o, stall_o, retry_cnt_o} !== 4'b1101) begin
      n_fail++;
      $display("FAIL reset_release: got req/stall/rc=%b%b%0d, want 1 1 1", retry_req_o, stall_o, retry_cnt_o);
    end
    step(0, '0, '0, '0, 0, 0, 0, 0);
  endtask
  task automatic test_single_retry();
    step(1, '0, '0, '0, 0, 0, 0, 1);
    step(1, '0, 4'b0010, '0, 1, 0, 0, 0);
    n_cmp++;
    if ({retry_req_o, stall_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL single_req: got req=%b stall=%b, want 1 1", retry_req_o, stall_o);
    end
    step(1, '0, '0, '0, 0, 0, 0, 0);
    step(1, '0, '0, '0, 0, 0, 0, 0);
    n_cmp++;
    if (retry_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_req_held: got req=%b, want 1", retry_req_o);
    end
    step(1, '0, '0, '0, 0, 0, 1, 0);
    n_cmp++;
    if ({retry_req_o, stall_o, retry_cnt_o} !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ack_drop: got req=%b stall=%b rc=%0d, want 0 0 1", retry_req_o, stall_o, retry_cnt_o);
    end
    step(1, '0, '0, '0, 1, 1, 0, 0);
    n_cmp++;
    if ({retry_cnt_o, maj_cnt_o, err_src_o, retry_req_o} !== {2'd0, 4'd1, 4'b0010, 1'b0}) begin
      n_fail++;
      $display("FAIL single_done: got rc=%0d maj=%0d src=%b req=%b, want 0 1 0010 0", retry_cnt_o, maj_cnt_o, err_src_o, retry_req_o);
    end
  endtask
  task automatic test_exhaust();
    step(0, '0, '0, '0, 0, 0, 0, 0);
    step(1, '0, 4'b0100, '0, 1, 0, 0, 0);
    step(1, '0, '0, '0, 0, 0, 1, 0);
    step(1, '0, 4'b0100, '0, 1, 0, 0, 0);
    n_cmp++;
    if ({retry_req_o, retry_cnt_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL exhaust_second_req: got req=%b rc=%0d, want 1 2", retry_req_o, retry_cnt_o);
    end
    step(1, '0, '0, '0, 0, 0, 1, 0);
    step(1, '0, 4'b0100, '0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({fatal_o, stall_o, retry_req_o} !== 3'b110) begin
        n_fail++;
        $display("FAIL exhaust_fatal[%0d]: got fatal=%b stall=%b req=%b, want 1 1 0", i, fatal_o, stall_o, retry_req_o);
      end
      step(1, '0, 4'(i), '0, 1, 1, 1, 0);
    end
    step(0, '0, '0, '0, 0, 0, 0, 0);
    n_cmp++;
    if ({fatal_o, stall_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL exhaust_reset: got fatal=%b stall=%b, want 0 0", fatal_o, stall_o);
    end
  endtask
  task automatic test_collision();
    step(1, '0, 4'b0001, '0, 1, 0, 0, 0);
    step(1, '0, '0, '0, 0, 0, 1, 0);
    step(1, '0, 4'b0001, '0, 1, 1, 0, 0);
    n_cmp++;
    if ({retry_req_o, stall_o, fatal_o, retry_cnt_o} !== 5'b11010) begin
      n_fail++;
      $display("FAIL collision_retry: got req=%b stall=%b fatal=%b rc=%0d, want 1 1 0 2", retry_req_o, stall_o, fatal_o, retry_cnt_o);
    end
    step(1, '0, '0, '0, 0, 0, 1, 0);
    step(1, '0, 4'b1001, '0, 1, 1, 0, 0);
    n_cmp++;
    if ({retry_req_o, stall_o, fatal_o} !== 3'b011) begin
      n_fail++;
      $display("FAIL collision_fatal: got req=%b stall=%b fatal=%b, want 0 1 1", retry_req_o, stall_o, fatal_o);
    end
    step(0, '0, '0, '0, 0, 0, 0, 0);
  endtask
  task automatic test_minor();
    for (int r = 0; r < 2; r++) begin
      step(1, '0, '0, '0, 0, 0, 0, 1);
      for (int k = 1; k <= 16; k++) begin
        step(1, 4'b0001, '0, '0, 0, 0, 0, 0);
        n_cmp++;
        if ({minor_alert_o, min_cnt_o} !== {k == MIN_THR, 4'(k > SAT ? SAT : k)}) begin
          n_fail++;
          $display("FAIL minor_round%0d_k%0d: got alert=%b min=%0d, want %b %0d", r, k, minor_alert_o, min_cnt_o,
                   k == MIN_THR, k > SAT ? SAT : k);
        end
      end
    end
  endtask
  task automatic test_saturation();
    step(1, '0, '0, '0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) step(1, '0, '0, 4'b1111, 0, 0, 0, 0);
    n_cmp++;
    if (scrub_cnt_o !== 4'd15) begin
      n_fail++;
      $display("FAIL scrub_saturate: got %0d, want 15", scrub_cnt_o);
    end
    step(1, '0, '0, 4'b1111, 0, 0, 0, 1);
    n_cmp++;
    if (scrub_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_priority: got %0d, want 0", scrub_cnt_o);
    end
  endtask
  task automatic test_random();
    logic [21:0] got, exp;
    step(0, '0, '0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(63) != 0,
           $urandom_range(2) == 0 ? 4'($urandom) : 4'd0,
           $urandom_range(5) == 0 ? 4'($urandom) : 4'd0,
           $urandom_range(2) == 0 ? 4'($urandom) : 4'd0,
           1'($urandom_range(1)), $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(40) == 0);
      got = {retry_req_o, stall_o, fatal_o, minor_alert_o, min_cnt_o, maj_cnt_o, scrub_cnt_o, err_src_o, retry_cnt_o};
      exp = {m_mode == M_REQ, m_mode == M_REQ || m_mode == M_FATAL, m_mode == M_FATAL, m_alert,
             4'(m_min), 4'(m_maj), 4'(m_scr), m_src, 2'(m_rc)};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h, want %h", i, got, exp);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single_retry();
    test_exhaust();
    test_collision();
    test_minor();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
